// File: rtl/aes_spi_framer.sv
// aes_spi_framer: frames SPI bytes into AES load operations. It collects a
// command byte and 16 data bytes, issues one load to the AES core, tracks the
// core's busy handshake, and returns the 128-bit result one byte at a time.
module aes_spi_framer #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [7:0]  CMD_ENC = 8'h45,
  parameter logic [7:0]  CMD_DEC = 8'h44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_i,
  input  logic [7:0]   rx_byte_i,
  input  logic         rx_valid_i,
  input  logic         tx_next_i,
  output logic [7:0]   tx_byte_o,
  output logic         aes_load_o,
  output logic         aes_dec_o,
  output logic [127:0] aes_data_o,
  input  logic [127:0] aes_data_i,
  input  logic         aes_busy_i,
  output logic         result_valid_o,
  output logic         err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_CMD, S_DATA, S_DROP, S_LOAD, S_WAIT, S_RUN, S_OUT
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [TW-1:0]  to_q, to_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   res_q, res_d;
  logic [3:0]     idx_q, idx_d;
  logic           dec_q, dec_d;
  logic           err_q, err_d;
  logic           rv_q, rv_d;
  logic [7:0]     tx_q, tx_d;
  logic [7:0]     res_byte;
  logic           to_hit;

  // Index 0 selects the most significant byte of the result.
  assign res_byte = res_d[{~idx_d, 3'b000} +: 8];
  assign to_hit   = (to_q == TW'(TIMEOUT - 1));

  // Next-state logic for the framing FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    data_d  = data_q;
    res_d   = res_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    err_d   = err_q;
    rv_d    = rv_q;
    case (state_q)
      S_CMD: begin
        if (!frame_i) begin
          cnt_d = '0;
        end else if (rx_valid_i) begin
          if (rx_byte_i == CMD_ENC || rx_byte_i == CMD_DEC) begin
            dec_d   = (rx_byte_i == CMD_DEC);
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_DATA: begin
        if (!frame_i) begin
          // Frame ended before all 16 data bytes arrived.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_CMD;
        end else if (rx_valid_i) begin
          data_d = {data_q[119:0], rx_byte_i};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_LOAD;
        end
      end
      S_DROP: begin
        if (!frame_i) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_LOAD: begin
        // The load cycle itself counts as the first timeout cycle.
        to_d    = TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        to_d = to_q + TW'(1);
        if (aes_busy_i) begin
          state_d = S_RUN;
        end else if (to_hit) begin
          err_d   = 1'b1;
          rv_d    = 1'b0;
          state_d = S_CMD;
        end
      end
      S_RUN: begin
        to_d = to_q + TW'(1);
        // A completing core wins over a coincident timeout.
        if (!aes_busy_i) begin
          res_d   = aes_data_i;
          rv_d    = 1'b1;
          idx_d   = '0;
          state_d = S_OUT;
        end else if (to_hit) begin
          err_d   = 1'b1;
          rv_d    = 1'b0;
          state_d = S_CMD;
        end
      end
      S_OUT: begin
        if (tx_next_i) begin
          if (idx_q == 4'd15) begin
            rv_d    = 1'b0;
            state_d = S_CMD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
    // The transmit byte is registered from next-state values, so it always
    // matches the state and flags visible in the same cycle.
    if (state_d == S_OUT) tx_d = res_byte;
    else tx_d = {6'b0, err_d, (state_d == S_WAIT) || (state_d == S_RUN)};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CMD;
      cnt_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      tx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      tx_q    <= tx_d;
    end
  end

  assign aes_load_o     = (state_q == S_LOAD);
  assign aes_dec_o      = dec_q;
  assign aes_data_o     = data_q;
  assign result_valid_o = rv_q;
  assign err_o          = err_q;
  assign tx_byte_o      = tx_q;

endmodule

// File: tb/tb_aes_spi_framer.sv
// Testbench for aes_spi_framer: a table of frames driven through a mock AES
// core, plus hand-written timeout and mid-operation reset sequences.
module tb_aes_spi_framer;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_i;
  logic [7:0]   rx_byte_i;
  logic         rx_valid_i;
  logic         tx_next_i;
  logic [7:0]   tx_byte_o;
  logic         aes_load_o;
  logic         aes_dec_o;
  logic [127:0] aes_data_o;
  logic [127:0] aes_data_i = '0;
  logic         aes_busy_i = 1'b0;
  logic         result_valid_o;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_spi_framer dut (
    .clk(clk), .rst(rst), .frame_i(frame_i), .rx_byte_i(rx_byte_i),
    .rx_valid_i(rx_valid_i), .tx_next_i(tx_next_i), .tx_byte_o(tx_byte_o),
    .aes_load_o(aes_load_o), .aes_dec_o(aes_dec_o), .aes_data_o(aes_data_o),
    .aes_data_i(aes_data_i), .aes_busy_i(aes_busy_i),
    .result_valid_o(result_valid_o), .err_o(err_o)
  );

  // Mock AES core: busy for 12 cycles after a load, result = input ^ 5A..5A.
  logic         mock_en = 1'b1;
  int           mock_cnt = 0;
  int           loads = 0;
  logic         load_dec = 1'b0;
  logic [127:0] load_data = '0;

  always @(posedge clk) begin
    if (aes_load_o) begin
      loads     <= loads + 1;
      load_dec  <= aes_dec_o;
      load_data <= aes_data_o;
    end
    if (aes_load_o && mock_en) begin
      aes_data_i <= aes_data_o ^ {16{8'h5A}};
      aes_busy_i <= 1'b1;
      mock_cnt   <= 12;
    end else if (aes_busy_i) begin
      mock_cnt <= mock_cnt - 1;
      if (mock_cnt == 1) aes_busy_i <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " tx_byte"}, 128'(tx_byte_o), 128'h00);
    chk({tag, " result_valid"}, 128'(result_valid_o), 128'h0);
    chk({tag, " err"}, 128'(err_o), 128'h0);
    chk({tag, " load"}, 128'(aes_load_o), 128'h0);
    chk({tag, " dec"}, 128'(aes_dec_o), 128'h0);
    chk({tag, " data"}, aes_data_o, 128'h0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         n;
    logic [7:0] base;
    logic       exp_load;
    logic       exp_dec;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_data;
    logic [7:0]   exp_byte;
    int           l0;

    vecs[0] = '{8'h45, 16, 8'h00, 1'b1, 1'b0, 1'b0}; // encrypt 00..0F
    vecs[1] = '{8'h44, 16, 8'h10, 1'b1, 1'b1, 1'b0}; // decrypt
    vecs[2] = '{8'h99, 16, 8'h20, 1'b0, 1'b0, 1'b1}; // bad command
    vecs[3] = '{8'h45, 16, 8'h30, 1'b1, 1'b0, 1'b0}; // clears err
    vecs[4] = '{8'h45,  7, 8'h40, 1'b0, 1'b0, 1'b1}; // short frame
    vecs[5] = '{8'h45, 16, 8'h50, 1'b1, 1'b0, 1'b0}; // no stale bytes
    vecs[6] = '{8'h44,  0, 8'h00, 1'b0, 1'b0, 1'b1}; // command only
    vecs[7] = '{8'h45, 16, 8'hA0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; frame_i = 1'b0; rx_byte_i = 8'h00; rx_valid_i = 1'b0; tx_next_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int v = 0; v < 8; v++) begin
      l0 = loads;
      exp_data = '0;
      frame_i = 1'b1;
      tick();
      send(vecs[v].cmd);
      for (int k = 0; k < vecs[v].n; k++) begin
        exp_byte = vecs[v].base + 8'(k);
        exp_data = {exp_data[119:0], exp_byte};
        send(exp_byte);
      end
      frame_i = 1'b0;
      tick();
      chk($sformatf("v%0d load count", v), 128'(loads - l0), 128'(vecs[v].exp_load));
      chk($sformatf("v%0d err", v), 128'(err_o), 128'(vecs[v].exp_err));
      if (vecs[v].exp_load) begin
        chk($sformatf("v%0d dec", v), 128'(load_dec), 128'(vecs[v].exp_dec));
        chk($sformatf("v%0d load data", v), load_data, exp_data);
        chk($sformatf("v%0d status busy", v), 128'(tx_byte_o), 128'h01);
        for (int t = 0; t < 40 && !result_valid_o; t++) tick();
        chk($sformatf("v%0d result_valid", v), 128'(result_valid_o), 128'h1);
        for (int i = 0; i < 16; i++) begin
          exp_byte = exp_data[127 - 8*i -: 8] ^ 8'h5A;
          chk($sformatf("v%0d tx byte %0d", v, i), 128'(tx_byte_o), 128'(exp_byte));
          tx_next_i = 1'b1;
          // Dummy read-frame bytes arrive alongside tx_next and must be ignored.
          if (i % 2 == 0) begin
            rx_byte_i  = 8'hEE;
            rx_valid_i = 1'b1;
          end
          tick();
          tx_next_i  = 1'b0;
          rx_valid_i = 1'b0;
        end
        chk($sformatf("v%0d result_valid after read", v), 128'(result_valid_o), 128'h0);
        chk($sformatf("v%0d status after read", v), 128'(tx_byte_o), 128'h00);
      end else begin
        chk($sformatf("v%0d status err", v), 128'(tx_byte_o), 128'h02);
      end
    end

    // Timeout: the core never raises busy.
    mock_en = 1'b0;
    frame_i = 1'b1;
    tick();
    send(8'h45);
    for (int k = 0; k < 16; k++) send(8'(k));
    chk("timeout load pulse", 128'(aes_load_o), 128'h1);
    for (int j = 1; j <= 64; j++) begin
      tick();
      if (j == 63) chk("timeout err before", 128'(err_o), 128'h0);
    end
    chk("timeout err", 128'(err_o), 128'h1);
    chk("timeout result_valid", 128'(result_valid_o), 128'h0);
    chk("timeout status", 128'(tx_byte_o), 128'h02);
    frame_i = 1'b0;
    tick();
    mock_en = 1'b1;

    // Reset while the core is running; the late result must not be captured.
    frame_i = 1'b1;
    tick();
    send(8'h44);
    for (int k = 0; k < 16; k++) send(8'h60 + 8'(k));
    frame_i = 1'b0;
    tick();
    chk("run status busy", 128'(tx_byte_o), 128'h01);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid-run reset");
    for (int t = 0; t < 20; t++) tick();
    chk("post-reset result_valid", 128'(result_valid_o), 128'h0);
    chk("post-reset status", 128'(tx_byte_o), 128'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
